// File: rtl/mm_pkg.sv
// mm_pkg: shared state encoding and drain length for the matrix-multiply feed scheduler
package mm_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_DRAIN, ST_DONE} state_t;
  function automatic int drain_cycles(input int n);
    return 2 * n - 1;
  endfunction
endpackage

// File: rtl/nRegisterChain.sv
// nRegisterChain: fixed-depth register delay line without reset
module nRegisterChain #(
  parameter int W = 16,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] r_q [DEPTH];
  always_ff @(posedge clk) begin
    r_q[0] <= d_i;
    for (int j = 1; j < DEPTH; j++) r_q[j] <= r_q[j-1];
  end
  assign q_o = r_q[DEPTH-1];
endmodule

// File: rtl/mm_feed_scheduler.sv
// mm_feed_scheduler: pulls k_len beats into skewed systolic lanes, then drains and signals done
module mm_feed_scheduler
  import mm_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 4,
  parameter int CW = 8
) (
  input  logic           Clock,
  input  logic           Resetn,
  input  logic           start,
  input  logic [CW-1:0]  k_len,
  input  logic           in_valid,
  input  logic [N*W-1:0] in_data,
  output logic           in_ready,
  output logic [N*W-1:0] lane_data,
  output logic [N-1:0]   lane_valid,
  output logic           acc_clear,
  output logic           busy,
  output logic           done
);
  localparam int DW = $clog2(2 * N);
  state_t        state_q;
  logic [CW-1:0] klen_q, beat_q;
  logic [DW-1:0] drain_q;
  logic          clr_q, acc;
  assign in_ready  = state_q == ST_FEED;
  assign busy      = state_q != ST_IDLE;
  assign done      = state_q == ST_DONE;
  assign acc_clear = clr_q;
  assign acc       = in_ready && in_valid;
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      klen_q  <= '0;
      beat_q  <= '0;
      drain_q <= '0;
      clr_q   <= 1'b0;
    end else begin
      clr_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) begin
          klen_q  <= k_len;
          beat_q  <= '0;
          clr_q   <= 1'b1;
          state_q <= (k_len == '0) ? ST_DONE : ST_FEED;
        end
        ST_FEED: if (in_valid) begin
          beat_q <= beat_q + 1'b1;
          if (beat_q == klen_q - 1'b1) begin
            state_q <= ST_DRAIN;
            drain_q <= DW'(drain_cycles(N));
          end
        end
        ST_DRAIN: if (drain_q == '0) state_q <= ST_DONE;
                  else drain_q <= drain_q - 1'b1;
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [W-1:0] din, dout;
    logic [i:0]   v_q;
    assign din = acc ? in_data[i*W +: W] : '0;
    nRegisterChain #(.W(W), .DEPTH(i + 1)) u_chain (.clk(Clock), .d_i(din), .q_o(dout));
    // valid runs alongside the data chain so reset can flush in-flight slots
    always_ff @(posedge Clock) v_q <= Resetn ? (i + 1)'({v_q, acc}) : '0;
    assign lane_valid[i]       = v_q[i];
    assign lane_data[i*W +: W] = v_q[i] ? dout : '0;
  end
endmodule

// File: tb/tb_mm_feed_scheduler.sv
// tb_mm_feed_scheduler: randomized and directed passes checked against a timestamp-based slot model
module tb_mm_feed_scheduler;
  localparam int W = 16, N = 4, CW = 8, MAXC = 20000;
  logic           Clock = 0, Resetn = 0, start = 0, in_valid = 0;
  logic [CW-1:0]  k_len = '0;
  logic [N*W-1:0] in_data = '0;
  logic           in_ready, acc_clear, busy, done;
  logic [N*W-1:0] lane_data;
  logic [N-1:0]   lane_valid;

  mm_feed_scheduler #(.W(W), .N(N), .CW(CW)) dut (
    .Clock(Clock), .Resetn(Resetn), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .lane_data(lane_data), .lane_valid(lane_valid), .acc_clear(acc_clear),
    .busy(busy), .done(done)
  );

  always #5 Clock = ~Clock;

  int ncmp = 0, nfail = 0, cyc = 0;
  int dacc = 0, last_acc = -1, dclr = 0, ddone = 0, last_done = -1;
  bit             hv [MAXC];
  logic [N*W-1:0] hd [MAXC];
  bit m_act = 0, m_feed = 0;
  int m_left = 0, m_done_at = -1, m_clr_at = -1, rmark = 0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    ncmp++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // slot history: each cycle either carries an accepted beat or a bubble
  task automatic model_edge();
    bit a;
    if (!Resetn) begin
      m_act = 0; m_feed = 0; m_done_at = -1; m_clr_at = -1;
      rmark = cyc + 1; hv[cyc] = 0;
    end else begin
      a = m_feed && in_valid;
      hv[cyc] = a; hd[cyc] = in_data;
      if (m_act && cyc == m_done_at) m_act = 0;
      else if (!m_act && start) begin
        m_act = 1; m_clr_at = cyc + 1;
        if (k_len == '0) m_done_at = cyc + 1;
        else begin m_feed = 1; m_left = int'(k_len); end
      end
      if (a) begin
        m_left--;
        if (m_left == 0) begin m_feed = 0; m_done_at = cyc + 2 * N + 1; end
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0]   ev;
    logic [N*W-1:0] ed;
    int idx;
    if (in_valid && in_ready === 1'b1) begin dacc++; last_acc = cyc; end
    @(posedge Clock);
    model_edge();
    cyc++;
    #1;
    ev = '0; ed = '0;
    for (int i = 0; i < N; i++) begin
      idx = cyc - 1 - i;
      if (idx >= 0 && idx >= rmark && hv[idx]) begin
        ev[i] = 1'b1;
        ed[i*W +: W] = hd[idx][i*W +: W];
      end
    end
    chk("in_ready", 64'(in_ready), 64'(m_feed));
    chk("busy", 64'(busy), 64'(m_act));
    chk("done", 64'(done), 64'(m_act && cyc == m_done_at));
    chk("acc_clear", 64'(acc_clear), 64'(cyc == m_clr_at));
    chk("lane_valid", 64'(lane_valid), 64'(ev));
    chk("lane_data", 64'(lane_data), 64'(ed));
    if (acc_clear === 1'b1) dclr++;
    if (done === 1'b1) begin ddone++; last_done = cyc; end
  endtask

  // vmode: 0 valid held high, 1 two-cycle gap after first beat, 2 random valid/data
  task automatic run_pass(input int k, input int vmode, input bit stray, output int t);
    int nacc, gap, guard;
    t = cyc; start = 1; k_len = CW'(k);
    tick();
    start = 0; gap = 0; guard = 0;
    while (m_act && guard < 5000) begin
      nacc = k - m_left;
      if (vmode == 1 && nacc == 1 && gap < 2 && m_feed) begin in_valid = 0; gap++; end
      else in_valid = (vmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data = (vmode == 2) ? {$urandom, $urandom} : {N{W'(nacc + 1)}};
      start = stray ? ($urandom_range(0, 2) == 0) : 1'b0;
      tick();
      guard++;
    end
    if (guard >= 5000) chk("pass_timeout", 64'(guard), 64'(0));
    start = 0; in_valid = 0;
  endtask

  initial begin
    int t, a0, c0, d0, g;
    tick(); tick();
    Resetn = 1;
    tick(); tick();

    a0 = dacc;
    run_pass(3, 0, 0, t);
    chk("p1_done_cyc", 64'(last_done), 64'(t + 12));
    chk("p1_accepts", 64'(dacc - a0), 64'(3));
    tick();

    run_pass(3, 1, 0, t);
    chk("p2_done_cyc", 64'(last_done), 64'(t + 14));
    tick();

    c0 = dclr; a0 = dacc;
    run_pass(0, 0, 0, t);
    chk("k0_done_cyc", 64'(last_done), 64'(t + 1));
    chk("k0_clears", 64'(dclr - c0), 64'(1));
    chk("k0_accepts", 64'(dacc - a0), 64'(0));
    tick();

    c0 = dclr; d0 = ddone;
    run_pass(5, 0, 1, t);
    tick(); tick();
    chk("stray_clears", 64'(dclr - c0), 64'(1));
    chk("stray_dones", 64'(ddone - d0), 64'(1));

    start = 1; k_len = CW'(2);
    tick();
    start = 0; in_valid = 1; in_data = {$urandom, $urandom};
    g = 0;
    while (lane_valid !== 4'b1100 && g < 20) begin
      tick(); in_data = {$urandom, $urandom}; g++;
    end
    chk("reach_1100", 64'(lane_valid), 64'(4'b1100));
    in_valid = 0; Resetn = 0;
    tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_lanes", 64'({lane_valid, lane_data}), 64'(0));
    Resetn = 1;
    tick();
    run_pass(4, 2, 0, t);
    tick();

    a0 = dacc;
    run_pass(255, 0, 0, t);
    chk("k255_accepts", 64'(dacc - a0), 64'(255));
    chk("k255_done_gap", 64'(last_done - last_acc), 64'(2 * N + 1));
    tick();

    for (int p = 0; p < 12; p++) begin
      run_pass($urandom_range(0, 20), 2, 1, t);
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
